// File: rtl/reg_alu_seq.sv
// Register-file sequencer: accepts one reg-to-reg instruction, reads both
// operands, runs the 8-bit ALU and writes the result back (IDLE/READ/EXEC/WB).
module reg_alu_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LDI, OP_NOP
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic [DATA_W:0]     sum, diff;

  assign instr_ready = (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (instr_valid) state_d = READ;
      READ: state_d = EXEC;
      EXEC: state_d = (op_q == OP_NOP) ? IDLE : WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Widened by one bit so the top bit is carry for ADD and borrow for SUB.
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
      OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = a_q;
      OP_LDI: alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= OP_NOP;
      rd_q   <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ra1    <= '0;
      ra2    <= '0;
      wa     <= '0;
      wdata  <= '0;
      we     <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          op_q  <= op_t'(op);
          rd_q  <= rd;
          imm_q <= imm;
          ra1   <= rs1;
          ra2   <= rs2;
        end
        READ: begin
          a_q <= rdata1;
          b_q <= rdata2;
        end
        EXEC: begin
          // done lands in WB, or in the following IDLE cycle for NOP.
          done <= 1'b1;
          if (op_q != OP_NOP) begin
            result <= alu_res;
            carry  <= alu_c;
            zero   <= (alu_res == '0);
            we     <= 1'b1;
            wa     <= rd_q;
            wdata  <= alu_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
